// File: rtl/poly_arb.sv
// poly_arb -- shares one poly_fun pipeline (fixed latency, no stall) among
// NREQ requesters. At most one operand is issued per cycle; a requester tag
// travels beside each operand so every result comes back with the ID of the
// requester that issued it.
//
// Build option: POLY_ARB_FIXED_PRI_EN -- when defined, the lowest-index valid
// requester always wins and last_grant stays at its reset value. When it is
// undefined (the default), the arbiter is round-robin.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   en               grant enable; in-flight results still drain when low
//   req_valid[NREQ]  per-requester operand valid
//   req_x            packed operands, requester i in [i*WIDTH +: WIDTH]
//   req_ready[NREQ]  one-hot combinational grant
//   pipe_x           registered operand to poly_fun x
//   pipe_y           poly_fun y
//   res_valid        one-cycle pulse per accepted operand
//   res_id           requester index of the current result
//   res_y            result, pipe_y passed straight through
//   busy             high while any tag is in flight
module poly_arb #(
  parameter  int WIDTH = 16,
  parameter  int NREQ  = 4,
  parameter  int LAT   = 3,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_x,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      pipe_x,
  input  logic [WIDTH-1:0]      pipe_y,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [WIDTH-1:0]      res_y,
  output logic                  busy
);

  logic [NREQ-1:0][WIDTH-1:0] xv;
  logic [IDW-1:0]             last_grant;
  logic [IDW-1:0]             gnt_id;
  logic                       hs;

  // Tag shift register: stage 0 is loaded at the handshake edge. The output
  // register behind the last stage places res_valid LAT edges after the
  // handshake, which lines it up with the poly_fun result.
  logic [LAT-1:0]             vld_pipe;
  logic [LAT-1:0][IDW-1:0]    id_pipe;

  assign xv = req_x;

`ifdef POLY_ARB_FIXED_PRI_EN
  // Scan downward so the lowest-index valid requester is the last write.
  always_comb begin
    hs     = 1'b0;
    gnt_id = '0;
    if (en && !rst) begin
      for (int i = NREQ-1; i >= 0; i--)
        if (req_valid[i]) begin
          hs     = 1'b1;
          gnt_id = IDW'(i);
        end
    end
  end
`else
  logic [IDW-1:0] idx;

  // Scan candidates from farthest to nearest after last_grant. The last hit
  // is then the first valid requester found when searching upward (with
  // wrap) from last_grant+1.
  always_comb begin
    hs     = 1'b0;
    gnt_id = '0;
    idx    = '0;
    if (en && !rst) begin
      for (int i = NREQ; i >= 1; i--) begin
        idx = IDW'((int'(last_grant) + i) % NREQ);
        if (req_valid[idx]) begin
          hs     = 1'b1;
          gnt_id = idx;
        end
      end
    end
  end
`endif

  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NREQ; j++)
      req_ready[j] = hs && (gnt_id == IDW'(j));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_x     <= '0;
      vld_pipe   <= '0;
      id_pipe    <= '0;
      last_grant <= IDW'(NREQ-1);
      res_valid  <= 1'b0;
      res_id     <= '0;
    end else begin
      // Idle cycles push a zero operand, so poly_fun always sees a defined x.
      pipe_x      <= hs ? xv[gnt_id] : '0;
      vld_pipe[0] <= hs;
      id_pipe[0]  <= hs ? gnt_id : '0;
      for (int s = 1; s < LAT; s++) begin
        vld_pipe[s] <= vld_pipe[s-1];
        id_pipe[s]  <= id_pipe[s-1];
      end
      res_valid <= vld_pipe[LAT-1];
      res_id    <= id_pipe[LAT-1];
`ifndef POLY_ARB_FIXED_PRI_EN
      if (hs) last_grant <= gnt_id;
`endif
    end
  end

  assign res_y = pipe_y;
  assign busy  = |vld_pipe;

endmodule
